// File: rtl/set_bit_enum_pkg.sv
// -----------------------------------------------------------------------------
// set_bit_enum_pkg
// Shared definitions for the set-bit enumerator:
//   - state_e   : controller states (IDLE waits for a word, EMIT streams indices)
//   - idxWidth  : index width needed to address every bit of a WIDTH-bit word
// -----------------------------------------------------------------------------
package set_bit_enum_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  // Index width for a WIDTH-bit word; WIDTH is at least 2, so this is >= 1.
  function automatic int idxWidth(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/set_bit_enumerator_lsb_index_enc.sv
// -----------------------------------------------------------------------------
// lsb_index_enc
// Combinational lowest-set-bit encoder.
// Ports:
//   vec : input vector
//   idx : index of the lowest set bit of vec (0 when vec is zero)
//   any : vec has at least one bit set
// -----------------------------------------------------------------------------
module lsb_index_enc
  import set_bit_enum_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int IDX_W = idxWidth(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scanning from the top down lets the lowest set bit win the final write.
  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

  assign any = |vec;

endmodule

// File: rtl/set_bit_enumerator.sv
// -----------------------------------------------------------------------------
// set_bit_enumerator
// Accepts one WIDTH-bit word over a valid/ready handshake and streams the index
// of every set bit, lowest first, one index per beat. An all-zero word yields a
// single beat flagged empty. A new word can be accepted in the same cycle as the
// last beat of the previous one, so consecutive words stream without a bubble.
//
// Ports:
//   clk_i         : clock, rising edge
//   srst_i        : synchronous active-high reset
//   data_i        : input word
//   data_valid_i  : data_i is valid
//   data_ready_o  : a word is accepted this cycle (combinational from idx_ready_i)
//   idx_o         : set-bit index of the current beat
//   idx_empty_o   : current beat represents an all-zero word
//   idx_last_o    : final beat of the current word
//   idx_valid_o   : beat valid
//   idx_ready_i   : consumer accepts the beat
//   total_o       : popcount of the word being emitted (only with the macro)
//
// Optional feature macro: SET_BIT_ENUM_TOTAL_EN adds total_o and its popcount.
// -----------------------------------------------------------------------------
module set_bit_enumerator
  import set_bit_enum_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int IDX_W = idxWidth(WIDTH)
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             data_valid_i,
  output logic             data_ready_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             idx_empty_o,
  output logic             idx_last_o,
  output logic             idx_valid_o,
`ifdef SET_BIT_ENUM_TOTAL_EN
  output logic [IDX_W:0]   total_o,
`endif
  input  logic             idx_ready_i
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             empty_q, empty_d;

  logic [IDX_W-1:0] lowestIdx;
  logic             anySet;
  logic [WIDTH-1:0] remCleared;
  logic             wordAccept;
  logic             beatAccept;

  lsb_index_enc #(
    .WIDTH (WIDTH)
  ) uLsbEnc (
    .vec (rem_q),
    .idx (lowestIdx),
    .any (anySet)
  );

  // rem with its lowest set bit removed; zero means the current beat is the last.
  assign remCleared = rem_q & (rem_q - WIDTH'(1));

  assign wordAccept = data_valid_i && data_ready_o;
  assign beatAccept = idx_valid_o && idx_ready_i;

  // State register and word storage.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= IDLE;
      rem_q   <= '0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      empty_q <= empty_d;
    end
  end

  // Next-state logic. A word loaded alongside the last beat overrides the
  // bit-clearing update and keeps the controller in EMIT.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    empty_d = empty_q;
    case (state_q)
      IDLE: begin
        if (wordAccept) begin
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (beatAccept && idx_last_o && !wordAccept) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (beatAccept) begin
      rem_d = remCleared;
    end
    if (wordAccept) begin
      rem_d   = data_i;
      empty_d = (data_i == '0);
    end
  end

  // Output logic. Beat fields are derived from the held word, so they stay
  // stable for as long as the consumer stalls. Reset masks both handshakes.
  always_comb begin
    idx_valid_o = 1'b0;
    idx_o       = '0;
    idx_last_o  = 1'b0;
    idx_empty_o = 1'b0;
    if (state_q == EMIT) begin
      idx_valid_o = !srst_i;
      idx_o       = anySet ? lowestIdx : '0;
      idx_last_o  = empty_q || (remCleared == '0);
      idx_empty_o = empty_q;
    end
    data_ready_o = !srst_i &&
                   ((state_q == IDLE) || (idx_valid_o && idx_last_o && idx_ready_i));
  end

`ifdef SET_BIT_ENUM_TOTAL_EN
  logic [IDX_W:0] popCount;
  logic [IDX_W:0] total_q;

  // Population count of the incoming word, captured only on acceptance.
  always_comb begin
    popCount = '0;
    for (int i = 0; i < WIDTH; i++) begin
      popCount = popCount + (IDX_W + 1)'(data_i[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      total_q <= '0;
    end else if (wordAccept) begin
      total_q <= popCount;
    end
  end

  assign total_o = total_q;
`endif

endmodule

// File: tb/tb_set_bit_enumerator.sv
// -----------------------------------------------------------------------------
// tb_set_bit_enumerator
// Directed self-checking bench for set_bit_enumerator (WIDTH=16). Inputs are
// driven shortly after each rising edge and outputs are checked before the
// next one.
// -----------------------------------------------------------------------------
module tb_set_bit_enumerator;

  localparam int WIDTH = 16;
  localparam int IDX_W = 4;

  logic             clk_i = 1'b0;
  logic             srst_i;
  logic [WIDTH-1:0] data_i;
  logic             data_valid_i;
  logic             data_ready_o;
  logic [IDX_W-1:0] idx_o;
  logic             idx_empty_o;
  logic             idx_last_o;
  logic             idx_valid_o;
  logic             idx_ready_i;
`ifdef SET_BIT_ENUM_TOTAL_EN
  logic [IDX_W:0]   total_o;
`endif

  int testsRun    = 0;
  int testsFailed = 0;

  set_bit_enumerator #(
    .WIDTH (WIDTH)
  ) dut (
    .clk_i        (clk_i),
    .srst_i       (srst_i),
    .data_i       (data_i),
    .data_valid_i (data_valid_i),
    .data_ready_o (data_ready_o),
    .idx_o        (idx_o),
    .idx_empty_o  (idx_empty_o),
    .idx_last_o   (idx_last_o),
    .idx_valid_o  (idx_valid_o),
`ifdef SET_BIT_ENUM_TOTAL_EN
    .total_o      (total_o),
`endif
    .idx_ready_i  (idx_ready_i)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk_i = ~clk_i;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  // Drive all handshake inputs at once, then let combinational outputs settle.
  task automatic applyStimulus(input logic rst, input logic [WIDTH-1:0] data,
                               input logic dValid, input logic iReady);
    srst_i       = rst;
    data_i       = data;
    data_valid_i = dValid;
    idx_ready_i  = iReady;
    #1;
  endtask

  // One comparison: count it, and on mismatch count and report it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Check every field of one output beat.
  task automatic expectBeat(input string tag, input int idx, input logic last,
                            input logic empty);
    checkOutput({tag, ".valid"}, 32'(idx_valid_o), 32'd1);
    checkOutput({tag, ".idx"},   32'(idx_o),       32'(idx));
    checkOutput({tag, ".last"},  32'(idx_last_o),  32'(last));
    checkOutput({tag, ".empty"}, 32'(idx_empty_o), 32'(empty));
  endtask

  initial begin
    // Reset held: both handshakes masked.
    applyStimulus(1'b1, '0, 1'b0, 1'b0);
    tick();
    #1;
    checkOutput("rst.ready", 32'(data_ready_o), 32'd0);
    checkOutput("rst.valid", 32'(idx_valid_o),  32'd0);
    tick();

    // First cycle after release.
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("rel.ready", 32'(data_ready_o), 32'd1);
    checkOutput("rel.valid", 32'(idx_valid_o),  32'd0);
    checkOutput("rel.idx",   32'(idx_o),        32'd0);
    checkOutput("rel.last",  32'(idx_last_o),   32'd0);
    checkOutput("rel.empty", 32'(idx_empty_o),  32'd0);
`ifdef SET_BIT_ENUM_TOTAL_EN
    checkOutput("rel.total", 32'(total_o),      32'd0);
`endif

    // Sparse word 0x8421: indices 0,5,10,15.
    applyStimulus(1'b0, 16'h8421, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 16'hDEAD, 1'b0, 1'b1);
    expectBeat("sparse0", 0, 1'b0, 1'b0);
`ifdef SET_BIT_ENUM_TOTAL_EN
    checkOutput("sparse.total", 32'(total_o), 32'd4);
`endif
    tick(); #1;
    expectBeat("sparse5", 5, 1'b0, 1'b0);
    tick(); #1;
    expectBeat("sparse10", 10, 1'b0, 1'b0);
    tick(); #1;
    expectBeat("sparse15", 15, 1'b1, 1'b0);
    checkOutput("sparse15.ready", 32'(data_ready_o), 32'd1);
    tick(); #1;
    checkOutput("sparse.idleValid", 32'(idx_valid_o), 32'd0);

    // Zero word: one empty, last beat.
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
    expectBeat("zero", 0, 1'b1, 1'b1);
`ifdef SET_BIT_ENUM_TOTAL_EN
    checkOutput("zero.total", 32'(total_o), 32'd0);
`endif
    tick(); #1;
    checkOutput("zero.idleValid", 32'(idx_valid_o), 32'd0);

    // Full word: 16 consecutive beats.
    applyStimulus(1'b0, 16'hFFFF, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      expectBeat($sformatf("full%0d", i), i, (i == 15), 1'b0);
`ifdef SET_BIT_ENUM_TOTAL_EN
      checkOutput("full.total", 32'(total_o), 32'd16);
`endif
      tick(); #1;
    end
    checkOutput("full.readyAfter", 32'(data_ready_o), 32'd1);
    checkOutput("full.validAfter", 32'(idx_valid_o),  32'd0);

    // Back-to-back: 0x0001 then 0x0003 with no bubble.
    applyStimulus(1'b0, 16'h0001, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 16'h0003, 1'b1, 1'b1);
    expectBeat("b2bA0", 0, 1'b1, 1'b0);
    checkOutput("b2bA0.ready", 32'(data_ready_o), 32'd1);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
    expectBeat("b2bB0", 0, 1'b0, 1'b0);
`ifdef SET_BIT_ENUM_TOTAL_EN
    checkOutput("b2b.total", 32'(total_o), 32'd2);
`endif
    tick(); #1;
    expectBeat("b2bB1", 1, 1'b1, 1'b0);
    tick(); #1;
    checkOutput("b2b.idleValid", 32'(idx_valid_o), 32'd0);

    // Backpressure on 0x0012: index 1 held through two stalls, then 4 last.
    applyStimulus(1'b0, 16'h0012, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    expectBeat("bp1s0", 1, 1'b0, 1'b0);
    checkOutput("bp1s0.ready", 32'(data_ready_o), 32'd0);
    tick(); #1;
    expectBeat("bp1s1", 1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
    expectBeat("bp1go", 1, 1'b0, 1'b0);
    tick(); #1;
    expectBeat("bp4", 4, 1'b1, 1'b0);
    tick(); #1;
    checkOutput("bp.idleValid", 32'(idx_valid_o), 32'd0);

    // Reset during the second beat of 0x00F0.
    applyStimulus(1'b0, 16'h00F0, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
    expectBeat("rstw4", 4, 1'b0, 1'b0);
    tick(); #1;
    expectBeat("rstw5", 5, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0000, 1'b0, 1'b1);
    checkOutput("rstw.validInRst", 32'(idx_valid_o),  32'd0);
    checkOutput("rstw.readyInRst", 32'(data_ready_o), 32'd0);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
    checkOutput("rstw.readyAfter", 32'(data_ready_o), 32'd1);
    checkOutput("rstw.validAfter", 32'(idx_valid_o),  32'd0);
    checkOutput("rstw.lastAfter",  32'(idx_last_o),   32'd0);
    tick(); #1;
    checkOutput("rstw.noStale", 32'(idx_valid_o), 32'd0);

    // Next word after reset: 0x0006 -> 1, 2.
    applyStimulus(1'b0, 16'h0006, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
    expectBeat("post1", 1, 1'b0, 1'b0);
    tick(); #1;
    expectBeat("post2", 2, 1'b1, 1'b0);
    tick(); #1;
    checkOutput("post.idleValid", 32'(idx_valid_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
